patgen_cfg_loader: RTL and testbench

//  Upstream configuration stage for the sync/async injection pattern generator.

---
 rtl/patgen_cfg_loader_if.sv | 30 +++
 rtl/patgen_cfg_loader.sv | 111 +++++++++++
 tb/tb_patgen_cfg_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/patgen_cfg_loader_if.sv
// Host/generator-facing bundle for the pattern-generator config loader.
// The slave modport is the loader's view; the master modport is the host/bench view.
interface patgen_cfg_loader_if;
  logic [7:0]  cfg_numpulses;
  logic [7:0]  cfg_periode;
  logic [15:0] cfg_runlen;
  logic [15:0] cfg_idelay;
  logic [15:0] cfg_clkfac;
  logic        load;
  logic        rearm;
  logic        abort;
  logic        busy;
  logic        loaded;
  logic        pg_rfg_write;
  logic [3:0]  pg_rfg_write_address;
  logic [7:0]  pg_rfg_write_data;
  logic        pg_resn;

  modport slave (
    input  cfg_numpulses, cfg_periode, cfg_runlen, cfg_idelay, cfg_clkfac,
    input  load, rearm, abort,
    output busy, loaded, pg_rfg_write, pg_rfg_write_address, pg_rfg_write_data, pg_resn
  );

  modport master (
    output cfg_numpulses, cfg_periode, cfg_runlen, cfg_idelay, cfg_clkfac,
    output load, rearm, abort,
    input  busy, loaded, pg_rfg_write, pg_rfg_write_address, pg_rfg_write_data, pg_resn
  );
endinterface

// File: rtl/patgen_cfg_loader.sv
// Snapshots a pulse configuration, streams it byte-wise onto the generator's register bus,
// then holds the generator in reset for RESET_HOLD cycles so it latches the new values.
module patgen_cfg_loader #(
  parameter int RESET_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  patgen_cfg_loader_if.slave  bus
);

  generate
    if (RESET_HOLD < 2 || RESET_HOLD > 255) begin : g_bad_hold
      $error("patgen_cfg_loader: RESET_HOLD must be in 2..255");
    end
  endgenerate

  localparam logic [7:0] HOLD = 8'(RESET_HOLD);

  typedef enum logic [1:0] {IDLE, WRITE, SETTLE} state_t;

  state_t          r_state;
  logic [2:0]      r_idx;
  logic [7:0]      r_cnt;
  logic [7:0][7:0] r_shadow;
  logic            r_write;
  logic [3:0]      r_addr;
  logic [7:0]      r_data;
  logic            r_resn;
  logic            r_busy;
  logic            r_loaded;

  logic [3:0]      w_addr;
  logic [7:0]      w_data;

  // Addresses run 7,8 then skip 9 and continue A..F.
  assign w_addr = (r_idx < 3'd2) ? ({1'b0, r_idx} + 4'd7) : ({1'b0, r_idx} + 4'd8);
  assign w_data = r_shadow[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_resn   <= 1'b0;
      r_busy   <= 1'b0;
      r_loaded <= 1'b0;
    end else if (bus.abort) begin
      r_state  <= IDLE;
      r_write  <= 1'b0;
      r_resn   <= 1'b0;
      r_busy   <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_write <= 1'b0;
          if (bus.load) begin
            // Element 0 is the first byte written.
            r_shadow <= {bus.cfg_clkfac[7:0], bus.cfg_clkfac[15:8],
                         bus.cfg_idelay[7:0], bus.cfg_idelay[15:8],
                         bus.cfg_runlen[7:0], bus.cfg_runlen[15:8],
                         bus.cfg_periode, bus.cfg_numpulses};
            r_idx    <= '0;
            r_state  <= WRITE;
          end else if (bus.rearm && r_loaded) begin
            r_cnt    <= '0;
            r_state  <= SETTLE;
          end
        end
        WRITE: begin
          r_write <= 1'b1;
          r_addr  <= w_addr;
          r_data  <= w_data;
          r_resn  <= 1'b0;
          r_busy  <= 1'b1;
          r_idx   <= r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            r_cnt   <= '0;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          r_write <= 1'b0;
          if (r_cnt == HOLD) begin
            r_resn   <= 1'b1;
            r_busy   <= 1'b0;
            r_loaded <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_resn <= 1'b0;
            r_busy <= 1'b1;
            r_cnt  <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy                 = r_busy;
  assign bus.loaded               = r_loaded;
  assign bus.pg_rfg_write         = r_write;
  assign bus.pg_rfg_write_address = r_addr;
  assign bus.pg_rfg_write_data    = r_data;
  assign bus.pg_resn              = r_resn;

endmodule

// File: tb/tb_patgen_cfg_loader.sv
// Directed bench: stimulus pushes expected register writes into a queue, a negedge monitor
// pops and compares each write; sequence timing is checked from the stimulus side.
module tb_patgen_cfg_loader;

  logic clk;
  logic rst;

  patgen_cfg_loader_if bus();

  patgen_cfg_loader #(.RESET_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int write_cnt = 0;
  logic [11:0] exp_q[$];

  logic [11:0] exp1 [8] = '{12'h703, 12'h810, 12'hA01, 12'hB02,
                            12'hC0A, 12'hD0B, 12'hE00, 12'hF01};
  logic [11:0] exp2 [8] = '{12'h75A, 12'h8C3, 12'hA12, 12'hB34,
                            12'hCBE, 12'hDEF, 12'hE80, 12'hF01};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] t [8], input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(t[i]);
  endtask

  task automatic set_cfg(input logic [7:0] np, input logic [7:0] pe,
                         input logic [15:0] rl, input logic [15:0] id, input logic [15:0] cf);
    bus.cfg_numpulses = np;
    bus.cfg_periode   = pe;
    bus.cfg_runlen    = rl;
    bus.cfg_idelay    = id;
    bus.cfg_clkfac    = cf;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called one time unit after an edge; returns one time unit after the sampling edge.
  task automatic pulse_load();
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
  endtask

  task automatic pulse_rearm();
    bus.rearm = 1'b1;
    step(1);
    bus.rearm = 1'b0;
  endtask

  // Walks cycles after the sampling edge until pg_resn rises (bounded), checking that busy
  // stays high and pg_resn low before the rise; optionally injects a strobe at cycle inj.
  task automatic run_seq(input string nm, input int rise, input int inj, input int kind);
    int got = -1;
    int bad = 0;
    for (int n = 1; n <= 40 && got < 0; n++) begin
      step(1);
      bus.load  = 1'b0;
      bus.rearm = 1'b0;
      if (bus.pg_resn === 1'b1) begin
        got = n;
        if (bus.busy !== 1'b0 || bus.loaded !== 1'b1) bad = 1;
      end else if (bus.busy !== 1'b1) begin
        bad = 1;
      end
      if (n == inj) begin
        if (kind == 1) bus.load = 1'b1;
        else           bus.rearm = 1'b1;
      end
    end
    chk({nm, " resn rise cycle"}, got, rise);
    chk({nm, " busy/resn profile"}, bad, 0);
  endtask

  // Monitor: every strobed write must match the head of the expected queue.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (bus.pg_rfg_write === 1'b1) begin
        write_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected write", {bus.pg_rfg_write_address, bus.pg_rfg_write_data}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("write addr:data", {bus.pg_rfg_write_address, bus.pg_rfg_write_data}, e);
        end
      end
    end
  end

  initial begin
    int base;
    int bad;
    rst       = 1'b1;
    bus.load  = 1'b0;
    bus.rearm = 1'b0;
    bus.abort = 1'b0;
    set_cfg(8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000);
    step(3);
    chk("reset write",  bus.pg_rfg_write, 0);
    chk("reset addr",   bus.pg_rfg_write_address, 0);
    chk("reset data",   bus.pg_rfg_write_data, 0);
    chk("reset resn",   bus.pg_resn, 0);
    chk("reset busy",   bus.busy, 0);
    chk("reset loaded", bus.loaded, 0);
    rst = 1'b0;
    step(1);

    // Rearm before any load is ignored
    base = write_cnt;
    pulse_rearm();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (bus.pg_resn !== 1'b0 || bus.busy !== 1'b0) bad = 1;
    end
    chk("rearm unloaded ignored", bad, 0);
    chk("rearm unloaded no writes", write_cnt - base, 0);

    // Test 1: basic load
    base = write_cnt;
    push(exp1, 8);
    set_cfg(8'h03, 8'h10, 16'h0102, 16'h0A0B, 16'h0001);
    pulse_load();
    run_seq("t1", 13, 0, 0);
    chk("t1 loaded", bus.loaded, 1);
    chk("t1 write count", write_cnt - base, 8);

    // Test 2: inputs change right after the snapshot
    base = write_cnt;
    push(exp2, 8);
    set_cfg(8'h5A, 8'hC3, 16'h1234, 16'hBEEF, 16'h8001);
    pulse_load();
    set_cfg(8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_seq("t2", 13, 0, 0);
    chk("t2 write count", write_cnt - base, 8);

    // Test 3: rearm pulses reset only
    base = write_cnt;
    pulse_rearm();
    run_seq("t3", 5, 0, 0);
    chk("t3 no writes", write_cnt - base, 0);
    chk("t3 loaded kept", bus.loaded, 1);

    // Test 4: second load during the 3rd write is dropped
    base = write_cnt;
    push(exp1, 8);
    set_cfg(8'h03, 8'h10, 16'h0102, 16'h0A0B, 16'h0001);
    pulse_load();
    run_seq("t4", 13, 3, 1);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (bus.busy !== 1'b0 || bus.pg_resn !== 1'b1) bad = 1;
    end
    chk("t4 no requeue", bad, 0);
    chk("t4 write count", write_cnt - base, 8);

    // Test 5: abort during write 5
    base = write_cnt;
    push(exp1, 5);
    pulse_load();
    step(5);
    bus.abort = 1'b1;
    step(1);
    chk("t5 abort write", bus.pg_rfg_write, 0);
    chk("t5 abort resn",  bus.pg_resn, 0);
    chk("t5 abort busy",  bus.busy, 0);
    chk("t5 abort loaded", bus.loaded, 0);
    bus.load = 1'b1;
    step(3);
    bus.load = 1'b0;
    step(2);
    chk("t5 load under abort busy", bus.busy, 0);
    chk("t5 write count", write_cnt - base, 5);
    bus.abort = 1'b0;
    step(1);
    base = write_cnt;
    push(exp1, 8);
    pulse_load();
    run_seq("t5 reload", 13, 0, 0);
    chk("t5 reload write count", write_cnt - base, 8);

    // Test 6: async reset mid-settle
    push(exp1, 8);
    pulse_load();
    step(10);
    #2 rst = 1'b1;
    #1;
    chk("t6 async write",  bus.pg_rfg_write, 0);
    chk("t6 async addr",   bus.pg_rfg_write_address, 0);
    chk("t6 async data",   bus.pg_rfg_write_data, 0);
    chk("t6 async resn",   bus.pg_resn, 0);
    chk("t6 async busy",   bus.busy, 0);
    chk("t6 async loaded", bus.loaded, 0);
    step(2);
    rst = 1'b0;
    step(3);
    chk("pending expected writes", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
